// File: rtl/branch_flag_unit.sv
// branch_flag_unit: latches ALU {Z,V,N} flags and resolves conditional branches
// and absolute jumps against them. Taken branches and jumps produce a one-cycle
// registered PC redirect followed by a multi-cycle flush window. Accepted and
// taken requests are counted with saturating counters.
module branch_flag_unit #(
  parameter int DSIZE        = 16,
  parameter int OFFSET_W     = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          flag_in,
  input  logic                flag_we,
  input  logic                br_valid,
  output logic                br_ready,
  input  logic [2:0]          br_cond,
  input  logic [OFFSET_W-1:0] br_offset,
  input  logic [DSIZE-1:0]    pc_in,
  input  logic                jump_valid,
  input  logic [DSIZE-1:0]    jump_target,
  output logic [2:0]          flags_q,
  output logic                redirect,
  output logic [DSIZE-1:0]    redirect_pc,
  output logic                flush,
  output logic [15:0]         br_count,
  output logic [15:0]         taken_count
);

  // Counter only needs to hold FLUSH_CYCLES-1 down to 0.
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t          state_r, state_next_s;
  logic [CW-1:0]   cnt_r, cnt_next_s;
  logic [2:0]      eval_flags_s;
  logic            jump_acc_s;
  logic            br_acc_s;
  logic            taken_s;
  logic [DSIZE-1:0] target_s;
  logic [DSIZE-1:0] offset_ext_s;
  logic            flag_upd_s;

  // Evaluate a condition code against {Z,V,N}.
  function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] f);
    logic z, v, n, r;
    z = f[2];
    v = f[1];
    n = f[0];
    case (cond)
      3'b000:  r = ~z;
      3'b001:  r = z;
      3'b010:  r = ~z & ~n;
      3'b011:  r = n;
      3'b100:  r = ~n;
      3'b101:  r = z | n;
      3'b110:  r = v;
      3'b111:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Saturating increment for the statistics counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? 16'hFFFF : c + 16'd1;
  endfunction

  // Request acceptance, flag forwarding and target computation.
  always_comb begin
    flag_upd_s   = flag_we & ~flush;
    eval_flags_s = flag_upd_s ? flag_in : flags_q;
    br_ready     = (state_r == ST_IDLE) & ~jump_valid;
    jump_acc_s   = jump_valid & (state_r == ST_IDLE);
    br_acc_s     = br_valid & br_ready;
    offset_ext_s = DSIZE'($signed(br_offset));
    if (jump_acc_s) begin
      taken_s  = 1'b1;
      target_s = jump_target;
    end else if (br_acc_s) begin
      taken_s  = cond_met(br_cond, eval_flags_s);
      target_s = pc_in + DSIZE'(1) + offset_ext_s;
    end else begin
      taken_s  = 1'b0;
      target_s = pc_in;
    end
  end

  // Next-state logic: a taken request opens the flush window, which then counts down.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (taken_s) begin
          state_next_s = ST_FLUSH;
          cnt_next_s   = CNT_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (cnt_r == CW'(0)) begin
          state_next_s = ST_IDLE;
        end else begin
          cnt_next_s = cnt_r - CW'(1);
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = CW'(0);
      end
    endcase
  end

  // State register and flush-window counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CW'(0);
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Registered outputs: flags, redirect pulse, flush and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q     <= 3'b000;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      flush       <= 1'b0;
      br_count    <= 16'h0000;
      taken_count <= 16'h0000;
    end else begin
      if (flag_upd_s) begin
        flags_q <= flag_in;
      end
      redirect <= taken_s;
      if (taken_s) begin
        redirect_pc <= target_s;
      end
      flush <= (state_next_s == ST_FLUSH);
      if (jump_acc_s | br_acc_s) begin
        br_count <= sat_inc(br_count);
      end
      if (taken_s) begin
        taken_count <= sat_inc(taken_count);
      end
    end
  end

endmodule

// File: tb/tb_branch_flag_unit.sv
// Self-checking bench for branch_flag_unit: directed scenarios plus a randomized
// run, all compared against a cycle-level behavioural model.
module tb_branch_flag_unit;
  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  flag_in;
  logic        flag_we;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_cond;
  logic [7:0]  br_offset;
  logic [15:0] pc_in;
  logic        jump_valid;
  logic [15:0] jump_target;
  logic [2:0]  flags_q;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        flush;
  logic [15:0] br_count;
  logic [15:0] taken_count;

  int tests = 0;
  int fails = 0;

  // Model state
  logic [2:0]  m_flags;
  int          m_left;
  logic        m_redirect;
  logic [15:0] m_rpc;
  int          m_brc;
  int          m_tkc;

  branch_flag_unit #(.DSIZE(16), .OFFSET_W(8), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .flag_in(flag_in), .flag_we(flag_we),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
    .br_offset(br_offset), .pc_in(pc_in), .jump_valid(jump_valid),
    .jump_target(jump_target), .flags_q(flags_q), .redirect(redirect),
    .redirect_pc(redirect_pc), .flush(flush), .br_count(br_count),
    .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  function automatic bit ref_cond(input logic [2:0] c, input logic [2:0] f);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return !n;
      3'd5: return z || n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic idle_inputs();
    rst = 1'b0; flag_in = 3'b000; flag_we = 1'b0; br_valid = 1'b0;
    br_cond = 3'b000; br_offset = 8'h00; pc_in = 16'h0000;
    jump_valid = 1'b0; jump_target = 16'h0000;
  endtask

  // Advance one clock with the currently driven inputs, updating the model.
  task automatic cycle();
    bit idle, jacc, bacc, tk;
    logic [2:0] ef;
    int t;
    idle = (m_left == 0);
    ef   = (flag_we && idle) ? flag_in : m_flags;
    jacc = jump_valid && idle;
    bacc = br_valid && idle && !jump_valid;
    tk   = jacc || (bacc && ref_cond(br_cond, ef));
    if (jacc) t = int'(jump_target);
    else      t = int'(pc_in) + 1 + int'($signed(br_offset));
    t = ((t % 65536) + 65536) % 65536;
    @(posedge clk);
    if (rst) begin
      m_flags = 3'b000; m_left = 0; m_redirect = 1'b0; m_rpc = 16'h0000;
      m_brc = 0; m_tkc = 0;
    end else begin
      if (flag_we && idle) m_flags = flag_in;
      m_redirect = tk;
      if (tk) m_rpc = t[15:0];
      if ((jacc || bacc) && m_brc < 65535) m_brc++;
      if (tk && m_tkc < 65535) m_tkc++;
      m_left = tk ? FC : ((m_left > 0) ? m_left - 1 : 0);
    end
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({flags_q, redirect, redirect_pc, flush, br_count, taken_count} !== 52'd0) begin
      fails++;
      $display("FAIL reset_outputs got flags=%b red=%b pc=%h fl=%b bc=%0d tc=%0d want all 0",
               flags_q, redirect, redirect_pc, flush, br_count, taken_count);
    end
    tests++;
    if (br_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", br_ready); end
  endtask

  task automatic test_eq_taken();
    do_reset();
    flag_we = 1'b1; flag_in = 3'b100; cycle();
    idle_inputs();
    br_valid = 1'b1; br_cond = 3'b001; pc_in = 16'h0010; br_offset = 8'h05; cycle();
    idle_inputs();
    tests++;
    if (redirect !== 1'b1 || redirect_pc !== 16'h0016 || flush !== 1'b1) begin
      fails++;
      $display("FAIL eq_redirect got red=%b pc=%h fl=%b want 1 0016 1", redirect, redirect_pc, flush);
    end
    tests++;
    if (br_ready !== 1'b0) begin fails++; $display("FAIL eq_ready_low got %b want 0", br_ready); end
    cycle();
    tests++;
    if (redirect !== 1'b0 || flush !== 1'b1 || br_ready !== 1'b0) begin
      fails++;
      $display("FAIL eq_flush2 got red=%b fl=%b rdy=%b want 0 1 0", redirect, flush, br_ready);
    end
    cycle();
    tests++;
    if (flush !== 1'b0 || br_ready !== 1'b1 || taken_count !== 16'd1) begin
      fails++;
      $display("FAIL eq_done got fl=%b rdy=%b tc=%0d want 0 1 1", flush, br_ready, taken_count);
    end
  endtask

  task automatic test_not_taken();
    do_reset();
    flag_we = 1'b1; flag_in = 3'b001; cycle();
    idle_inputs();
    br_valid = 1'b1; br_cond = 3'b100; pc_in = 16'h0040; br_offset = 8'h02; cycle();
    idle_inputs();
    tests++;
    if (redirect !== 1'b0 || flush !== 1'b0 || br_count !== 16'd1 || taken_count !== 16'd0
        || flags_q !== 3'b001) begin
      fails++;
      $display("FAIL ge_not_taken got red=%b fl=%b bc=%0d tc=%0d fq=%b want 0 0 1 0 001",
               redirect, flush, br_count, taken_count, flags_q);
    end
  endtask

  task automatic test_forward();
    do_reset();
    flag_we = 1'b1; flag_in = 3'b100;
    br_valid = 1'b1; br_cond = 3'b000; pc_in = 16'h0100; br_offset = 8'h01; cycle();
    idle_inputs();
    tests++;
    if (redirect !== 1'b0 || flush !== 1'b0 || br_count !== 16'd1 || flags_q !== 3'b100) begin
      fails++;
      $display("FAIL forward_ne got red=%b fl=%b bc=%0d fq=%b want 0 0 1 100",
               redirect, flush, br_count, flags_q);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    br_valid = 1'b1; br_cond = 3'b111; pc_in = 16'hFFFE; br_offset = 8'h03; cycle();
    idle_inputs();
    tests++;
    if (redirect !== 1'b1 || redirect_pc !== 16'h0002) begin
      fails++; $display("FAIL wrap_up got red=%b pc=%h want 1 0002", redirect, redirect_pc);
    end
    cycle(); cycle();
    br_valid = 1'b1; br_cond = 3'b111; pc_in = 16'h0001; br_offset = 8'hFC; cycle();
    idle_inputs();
    tests++;
    if (redirect !== 1'b1 || redirect_pc !== 16'hFFFE || br_count !== 16'd2) begin
      fails++;
      $display("FAIL wrap_down got red=%b pc=%h bc=%0d want 1 fffe 2", redirect, redirect_pc, br_count);
    end
    cycle(); cycle();
  endtask

  task automatic test_jump_priority();
    do_reset();
    jump_valid = 1'b1; jump_target = 16'h1234;
    br_valid = 1'b1; br_cond = 3'b111; pc_in = 16'h0200; br_offset = 8'h10;
    #1;
    tests++;
    if (br_ready !== 1'b0) begin fails++; $display("FAIL jump_blocks_ready got %b want 0", br_ready); end
    cycle();
    jump_valid = 1'b0;
    tests++;
    if (redirect !== 1'b1 || redirect_pc !== 16'h1234 || br_count !== 16'd1) begin
      fails++;
      $display("FAIL jump_redirect got red=%b pc=%h bc=%0d want 1 1234 1", redirect, redirect_pc, br_count);
    end
    flag_we = 1'b1; flag_in = 3'b111;
    cycle(); cycle();
    flag_we = 1'b0;
    tests++;
    if (flags_q !== 3'b000 || br_count !== 16'd1) begin
      fails++; $display("FAIL flush_drop got fq=%b bc=%0d want 000 1", flags_q, br_count);
    end
    cycle();
    idle_inputs();
    tests++;
    if (redirect !== 1'b1 || redirect_pc !== 16'h0211 || br_count !== 16'd2) begin
      fails++;
      $display("FAIL held_branch got red=%b pc=%h bc=%0d want 1 0211 2", redirect, redirect_pc, br_count);
    end
    cycle(); cycle();
  endtask

  task automatic test_reset_in_flush();
    do_reset();
    jump_valid = 1'b1; jump_target = 16'h0abc; cycle();
    idle_inputs();
    rst = 1'b1; cycle(); rst = 1'b0;
    tests++;
    if (flush !== 1'b0 || redirect !== 1'b0 || br_ready !== 1'b1 || br_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_in_flush got fl=%b red=%b rdy=%b bc=%0d want 0 0 1 0",
               flush, redirect, br_ready, br_count);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 63) == 0);
      flag_we     = $urandom_range(0, 1);
      flag_in     = 3'($urandom);
      br_valid    = $urandom_range(0, 1);
      br_cond     = 3'($urandom);
      br_offset   = 8'($urandom);
      pc_in       = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
      jump_valid  = ($urandom_range(0, 7) == 0);
      jump_target = 16'($urandom);
      cycle();
      tests++;
      if (flags_q !== m_flags || redirect !== m_redirect || redirect_pc !== m_rpc
          || flush !== (m_left > 0) || br_ready !== (m_left == 0 && !jump_valid)
          || br_count !== 16'(m_brc) || taken_count !== 16'(m_tkc)) begin
        fails++;
        $display("FAIL random_%0d got fq=%b red=%b pc=%h fl=%b rdy=%b bc=%0d tc=%0d want fq=%b red=%b pc=%h fl=%b rdy=%b bc=%0d tc=%0d",
                 i, flags_q, redirect, redirect_pc, flush, br_ready, br_count, taken_count,
                 m_flags, m_redirect, m_rpc, (m_left > 0), (m_left == 0 && !jump_valid), m_brc, m_tkc);
      end
    end
    idle_inputs();
  endtask

  initial begin
    m_flags = 3'b000; m_left = 0; m_redirect = 1'b0; m_rpc = 16'h0000; m_brc = 0; m_tkc = 0;
    idle_inputs();
    test_reset();
    test_eq_taken();
    test_not_taken();
    test_forward();
    test_wrap();
    test_jump_priority();
    test_reset_in_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
